// File: rtl/mem_access_stage.sv
// Memory stage between EX/MEM and MEM/WB: issues loads/stores on a req/ack port,
// stalls upstream while the access is outstanding, and registers the writeback bundle.
module mem_access_stage #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       ALURi,
  input  logic [31:0]       stdatai,
  input  logic [3:0]        WrDesti,
  input  logic              wmemi,
  input  logic              rmemi,
  input  logic              wregi,
  input  logic              jmpi,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [3:0]        wb_dest,
  output logic              wb_wreg,
  output logic              wb_jmp,
  output logic              mem_err
);

  // state   | meaning
  // ST_IDLE | accepting instructions; ALU ops retire next cycle
  // ST_WAIT | request outstanding, waiting for mem_ack or timeout

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       alu_q, alu_d;
  logic [3:0]        dest_q, dest_d;
  logic              wreg_q, wreg_d;
  logic              jmp_q, jmp_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [3:0]        wb_dest_q, wb_dest_d;
  logic              wb_wreg_q, wb_wreg_d;
  logic              wb_jmp_q, wb_jmp_d;
  logic              mem_err_q, mem_err_d;

  logic mem_op;
  logic aligned;

  assign mem_op  = wmemi | rmemi;
  assign aligned = (ALURi[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alu_d       = alu_q;
    dest_d      = dest_q;
    wreg_d      = wreg_q;
    jmp_d       = jmp_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    wb_wreg_d   = wb_wreg_q;
    wb_jmp_d    = wb_jmp_q;
    mem_err_d   = mem_err_q;
    stall       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ALURi;
            wb_dest_d  = WrDesti;
            wb_wreg_d  = wregi;
            wb_jmp_d   = jmpi;
          end else if (aligned) begin
            stall       = 1'b1;
            mem_req_d   = 1'b1;
            mem_we_d    = wmemi;
            mem_addr_d  = ALURi[ADDR_W+1:2];
            mem_wdata_d = stdatai;
            alu_d       = ALURi;
            dest_d      = WrDesti;
            wreg_d      = wregi;
            jmp_d       = jmpi;
            cnt_d       = CNT_LOAD;
            state_d     = ST_WAIT;
          end else begin
            // misaligned: retire immediately without touching memory
            mem_err_d  = 1'b1;
            wb_valid_d = 1'b1;
            wb_data_d  = ALURi;
            wb_dest_d  = WrDesti;
            wb_wreg_d  = 1'b0;
            wb_jmp_d   = jmpi;
          end
        end
      end

      ST_WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = mem_we_q ? alu_q : mem_rdata;
          wb_wreg_d  = mem_we_q ? 1'b0 : wreg_q;
          wb_dest_d  = dest_q;
          wb_jmp_d   = jmp_q;
          state_d    = ST_IDLE;
        end else if (cnt_q == '0) begin
          mem_err_d  = 1'b1;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = alu_q;
          wb_wreg_d  = 1'b0;
          wb_dest_d  = dest_q;
          wb_jmp_d   = jmp_q;
          state_d    = ST_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      alu_q       <= '0;
      dest_q      <= '0;
      wreg_q      <= 1'b0;
      jmp_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_wreg_q   <= 1'b0;
      wb_jmp_q    <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      alu_q       <= alu_d;
      dest_q      <= dest_d;
      wreg_q      <= wreg_d;
      jmp_q       <= jmp_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_wreg_q   <= wb_wreg_d;
      wb_jmp_q    <= wb_jmp_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_dest   = wb_dest_q;
  assign wb_wreg   = wb_wreg_q;
  assign wb_jmp    = wb_jmp_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table for single-cycle behaviour,
// hand-written sequences for loads, stores, timeout and reset mid-access.
module tb_mem_access_stage;

  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [31:0]       ALURi;
  logic [31:0]       stdatai;
  logic [3:0]        WrDesti;
  logic              wmemi, rmemi, wregi, jmpi;
  logic              stall;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [3:0]        wb_dest;
  logic              wb_wreg, wb_jmp, mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALURi(ALURi), .stdatai(stdatai),
    .WrDesti(WrDesti), .wmemi(wmemi), .rmemi(rmemi), .wregi(wregi), .jmpi(jmpi),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_wreg(wb_wreg),
    .wb_jmp(wb_jmp), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [3:0] d, input logic wm, input logic rm,
                       input logic wr, input logic j);
    in_valid = v; ALURi = alu; stdatai = sd; WrDesti = d;
    wmemi = wm; rmemi = rm; wregi = wr; jmpi = j;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_wb_data", wb_data, 0);
  endtask

  // Setup cycle plus first WAIT-cycle request check; leaves in_valid asserted.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] d,
                       input logic wm, input logic rm, input logic wr, input logic j,
                       input logic exp_we, input logic [31:0] exp_addr);
    drive(1'b1, alu, sd, d, wm, rm, wr, j);
    #1;
    chk("setup_stall", stall, 1);
    tick();
    chk("req_issued", mem_req, 1);
    chk("req_we", mem_we, exp_we);
    chk("req_addr", 32'(mem_addr), exp_addr);
    chk("req_wdata", mem_wdata, sd);
  endtask

  // WAIT phase: ack on cycle ack_at (0 = never). Returns just after the completion edge.
  task automatic run_wait(input int ack_at, input logic [31:0] rdata);
    for (int n = 1; n <= TIMEOUT; n++) begin
      mem_ack   = (n == ack_at);
      mem_rdata = rdata;
      #1;
      chk("wait_stall", stall, ((n == ack_at) || (n == TIMEOUT)) ? 0 : 1);
      chk("wait_req_held", mem_req, 1);
      tick();
      mem_ack = 1'b0;
      if ((n == ack_at) || (n == TIMEOUT)) break;
      chk("wait_wb_valid", wb_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        in_valid;
    logic [31:0] alu;
    logic [3:0]  dest;
    logic        wmem, rmem, wreg, jmp, ack;
    logic        e_stall, e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_dest;
    logic        e_wreg, e_jmp, e_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 32'h11,   4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11,   4'd3, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h22,   4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22,   4'd3, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h99,   4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h22,   4'd3, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h1234, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 4'd7, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h42,   4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42,   4'd5, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 32'h13,   4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13,   4'd2, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 32'h0,    4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h13,   4'd2, 1'b0, 1'b1, 1'b1};

    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].in_valid, tbl[i].alu, 32'h5555, tbl[i].dest, tbl[i].wmem, tbl[i].rmem,
            tbl[i].wreg, tbl[i].jmp);
      mem_ack = tbl[i].ack;
      #1;
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("v%0d_wb_valid", i), wb_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_wb_data", i), wb_data, tbl[i].e_data);
      chk($sformatf("v%0d_wb_dest", i), wb_dest, tbl[i].e_dest);
      chk($sformatf("v%0d_wb_wreg", i), wb_wreg, tbl[i].e_wreg);
      chk($sformatf("v%0d_wb_jmp", i), wb_jmp, tbl[i].e_jmp);
      chk($sformatf("v%0d_mem_err", i), mem_err, tbl[i].e_err);
      chk($sformatf("v%0d_mem_req", i), mem_req, 0);
    end

    // Reset in the middle of an outstanding access.
    do_reset();
    issue(32'h40, 32'h0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
    mem_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_mem_err", mem_err, 0);
    drive(1'b1, 32'h77, 32'h0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("midrst_idle_stall", stall, 0);
    tick();
    in_valid = 1'b0;
    chk("midrst_idle_wb_valid", wb_valid, 1);
    chk("midrst_idle_wb_data", wb_data, 32'h77);

    // Load, ack on the third WAIT cycle.
    issue(32'h40, 32'h0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10);
    run_wait(3, 32'hDEADBEEF);
    chk("load_wb_valid", wb_valid, 1);
    chk("load_wb_data", wb_data, 32'hDEADBEEF);
    chk("load_wb_wreg", wb_wreg, 1);
    chk("load_wb_dest", wb_dest, 6);
    chk("load_wb_jmp", wb_jmp, 1);
    chk("load_req_drop", mem_req, 0);
    tick();
    chk("load_wb_pulse", wb_valid, 0);
    chk("load_wb_data_hold", wb_data, 32'hDEADBEEF);

    // Store with immediate ack; rmemi also set, store must win.
    issue(32'h8, 32'hCAFE, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2);
    run_wait(1, 32'h12345678);
    chk("store_wb_valid", wb_valid, 1);
    chk("store_wb_data", wb_data, 32'h8);
    chk("store_wb_wreg", wb_wreg, 0);
    chk("store_mem_err", mem_err, 0);

    // Timeout with no ack.
    issue(32'h80, 32'h0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
    run_wait(0, 32'h0);
    chk("tmo_wb_valid", wb_valid, 1);
    chk("tmo_wb_wreg", wb_wreg, 0);
    chk("tmo_wb_data", wb_data, 32'h80);
    chk("tmo_mem_req", mem_req, 0);
    chk("tmo_mem_err", mem_err, 1);
    tick();
    chk("tmo_err_sticky", mem_err, 1);
    chk("tmo_req_stays_low", mem_req, 0);

    // Ack arriving on the timeout cycle: normal completion.
    do_reset();
    issue(32'h80, 32'h0, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
    run_wait(TIMEOUT, 32'hA5A5F00D);
    chk("lateack_wb_valid", wb_valid, 1);
    chk("lateack_wb_data", wb_data, 32'hA5A5F00D);
    chk("lateack_wb_wreg", wb_wreg, 1);
    chk("lateack_mem_err", mem_err, 0);
    chk("lateack_mem_req", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
